// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: pedestrian FSM states and default phase timing.
package tl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WALK  = 3'd2,
    S_FLASH = 3'd3,
    S_CLEAR = 3'd4
  } ped_state_t;

  localparam int DEF_WALK_CYC   = 128;
  localparam int DEF_FLASH_CYC  = 64;
  localparam int DEF_BLINK_HALF = 8;

  function automatic int tl_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw push-button followed by a rising-edge detector.
module btn_sync (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (res) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller: latches button requests and runs walk/flash
// phases only on a fresh vehicle-red edge, aborting if red is withdrawn.
module ped_crossing
  import tl_pkg::*;
#(
  parameter int WALK_CYC   = DEF_WALK_CYC,
  parameter int FLASH_CYC  = DEF_FLASH_CYC,
  parameter int BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       res,
  input  logic       veh_red,
  input  logic       btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [7:0] served_cnt
);

  localparam int CW = $clog2(tl_max(WALK_CYC, FLASH_CYC)) + 1;
  localparam int BW = $clog2(BLINK_HALF) + 1;

  ped_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] blink, blink_n;
  logic          walk_n, dw_n, req_n;
  logic [7:0]    served_n;
  logic          veh_red_q, red_edge, req_edge;

  btn_sync u_btn_sync (
    .clk  (clk),
    .res  (res),
    .btn  (btn),
    .rise (req_edge)
  );

  // Resets high so a red phase already running at release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (res) veh_red_q <= 1'b1;
    else     veh_red_q <= veh_red;
  end

  assign red_edge = veh_red & ~veh_red_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= S_IDLE;
      cnt         <= '0;
      blink       <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      served_cnt  <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      blink       <= blink_n;
      walk        <= walk_n;
      dont_walk   <= dw_n;
      req_pending <= req_n;
      served_cnt  <= served_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = '0;
    blink_n  = '0;
    walk_n   = 1'b0;
    dw_n     = 1'b1;
    req_n    = req_pending | req_edge;
    served_n = served_cnt;
    case (state)
      S_IDLE: begin
        if (req_edge) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (red_edge) begin
          state_n  = S_WALK;
          walk_n   = 1'b1;
          dw_n     = 1'b0;
          req_n    = 1'b0;
          served_n = served_cnt + 8'd1;
        end
      end
      S_WALK: begin
        if (!veh_red) begin
          state_n = req_n ? S_WAIT : S_IDLE;
        end else if (cnt == CW'(WALK_CYC - 1)) begin
          state_n = S_FLASH;
        end else begin
          cnt_n  = cnt + 1'b1;
          walk_n = 1'b1;
          dw_n   = 1'b0;
        end
      end
      S_FLASH: begin
        if (!veh_red) begin
          state_n = req_n ? S_WAIT : S_IDLE;
        end else if (cnt == CW'(FLASH_CYC - 1)) begin
          state_n = S_CLEAR;
        end else begin
          cnt_n = cnt + 1'b1;
          // Lamp toggles when a half-period of blink cycles completes.
          if (blink == BW'(BLINK_HALF - 1)) begin
            blink_n = '0;
            dw_n    = ~dont_walk;
          end else begin
            blink_n = blink + 1'b1;
            dw_n    = dont_walk;
          end
        end
      end
      S_CLEAR: begin
        if (!veh_red) state_n = req_n ? S_WAIT : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
